// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: controller states, command bytes and parity helper.
// Also imported by the keyboard receive path.
package ps2_host_tx_pkg;

    // Host-to-device transmit controller states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRts   = 3'd1,
        StStart = 3'd2,
        StData  = 3'd3,
        StStop  = 3'd4,
        StAck   = 3'd5
    } ps2_tx_state_e;

    // Common keyboard command bytes
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;

    // Odd parity: total number of ones over data plus parity is odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter. The filtered level only changes once the last
// FILTER_LEN samples agree; o_fall_tick marks a filtered 1->0 transition.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2c,
    output logic o_fall_tick
);

    logic [FILTER_LEN-1:0] r_shift;
    logic                  r_level;
    logic                  w_level_next;

    // Sample the raw line and register the filtered level
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '1;
            r_level <= 1'b1;
        end else begin
            r_shift <= {i_ps2c, r_shift[FILTER_LEN-1:1]};
            r_level <= w_level_next;
        end
    end

    // Level moves only on a unanimous shift register, otherwise holds
    always_comb begin
        w_level_next = r_level;
        if (&r_shift) begin
            w_level_next = 1'b1;
        end else if (~|r_shift) begin
            w_level_next = 1'b0;
        end
    end

    assign o_fall_tick = r_level & ~w_level_next;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Issues request-to-send, then shifts out
// start, eight data bits LSB first, odd parity and stop on device clock
// falling edges, and finally checks the device ACK. Lines are open-drain.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int unsigned MaxCycles =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutVal  = CntW'(TIMEOUT_CYCLES);

    ps2_tx_state_e   r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [3:0]      r_n, w_n_next;
    logic [8:0]      r_frame, w_frame_next;

    logic w_fall_tick;
    logic w_timeout;
    logic w_drive_c;
    logic w_drive_d;
    logic w_ps2d_in;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk         (clk),
        .reset       (reset),
        .i_ps2c      (ps2c),
        .o_fall_tick (w_fall_tick)
    );

    assign w_ps2d_in = ps2d;
    // Watchdog value is only meaningful in the device-clocked states
    assign w_timeout = (r_cnt == TimeoutVal);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_n     <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_n     <= w_n_next;
            r_frame <= w_frame_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_n_next     = r_n;
        w_frame_next = r_frame;
        unique case (r_state)
            StIdle: begin
                if (wr_ps2) begin
                    w_frame_next = {odd_parity(din), din};
                    w_cnt_next   = '0;
                    w_state_next = StRts;
                end
            end
            StRts: begin
                if (r_cnt == InhibitLast) begin
                    w_cnt_next   = '0;
                    w_state_next = StStart;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            StStart, StData, StStop, StAck: begin
                if (w_timeout) begin
                    w_cnt_next   = '0;
                    w_state_next = StIdle;
                end else if (w_fall_tick) begin
                    w_cnt_next = '0;
                    unique case (r_state)
                        StStart: begin
                            w_n_next     = 4'd8;
                            w_state_next = StData;
                        end
                        StData: begin
                            w_frame_next = {1'b0, r_frame[8:1]};
                            if (r_n == 4'd0) begin
                                w_state_next = StStop;
                            end else begin
                                w_n_next = r_n - 1'b1;
                            end
                        end
                        StStop:  w_state_next = StAck;
                        default: w_state_next = StIdle;
                    endcase
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Line drives and status outputs decoded from state
    always_comb begin
        tx_idle      = (r_state == StIdle);
        tx_done_tick = 1'b0;
        tx_err       = 1'b0;
        w_drive_c    = 1'b0;
        w_drive_d    = 1'b0;
        unique case (r_state)
            StRts:   w_drive_c = 1'b1;
            StStart: begin
                w_drive_d = 1'b1;
                tx_err    = w_timeout;
            end
            StData: begin
                w_drive_d = ~r_frame[0];
                tx_err    = w_timeout;
            end
            StStop:  tx_err = w_timeout;
            StAck: begin
                // Device pulls data low for ACK; sampled on its clock fall
                tx_done_tick = ~w_timeout & w_fall_tick & ~w_ps2d_in;
                tx_err       = w_timeout | (w_fall_tick & w_ps2d_in);
            end
            default: ;
        endcase
    end

    assign ps2c = w_drive_c ? 1'b0 : 1'bz;
    assign ps2d = w_drive_d ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with pull-ups and a behavioural
// PS/2 device that clocks the frame and optionally ACKs.
module tb_ps2_host_tx;

    localparam int unsigned INHIBIT = 50;
    localparam int unsigned TIMEOUT = 2000;
    localparam int unsigned HALF    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    logic dev_c = 1'b0;
    logic dev_d = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    // Count status pulses seen away from the active edge
    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) n_done++;
        if (tx_err === 1'b1) n_err++;
        if (tx_done_tick === 1'b1 && tx_err === 1'b1) n_both++;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: wire frame as the device sees it, index 0 = start bit
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i+1] = b[i];
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_req(input logic [7:0] b);
        @(negedge clk);
        wr_ps2 = 1'b1;
        din    = b;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'h00;
    endtask

    // Returns on the first cycle ps2c is high again
    task automatic measure_rts(output int len);
        len = 0;
        while (ps2c === 1'b0 && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic dev_pulse(output logic smp, input logic glitch, input logic inj);
        dev_c = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c = 1'b0;
        @(negedge clk);
        smp = ps2d;
        if (inj) begin
            wr_ps2 = 1'b1;
            din    = 8'hAA;
            @(negedge clk);
            wr_ps2 = 1'b0;
            din    = 8'h00;
            repeat (HALF - 2) @(negedge clk);
        end else if (glitch) begin
            repeat (12) @(negedge clk);
            dev_c = 1'b1;
            repeat (3) @(negedge clk);
            dev_c = 1'b0;
            repeat (HALF - 16) @(negedge clk);
        end else begin
            repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic do_xfer(input string tag, input logic [7:0] b, input logic ack,
                           input logic glitch, input logic inj);
        logic [10:0] got;
        logic        smp;
        int          len;
        n_done = 0;
        n_err  = 0;
        n_both = 0;
        start_req(b);
        measure_rts(len);
        check_val({tag, "_rts_len"}, len, INHIBIT);
        repeat (30) @(negedge clk);
        got[0] = ps2d;
        for (int i = 1; i <= 12; i++) begin
            if (i == 11) dev_d = ack;
            dev_pulse(smp, glitch && (i % 3 == 1), inj && (i == 5));
            if (i <= 10) got[i] = smp;
        end
        repeat (5) @(negedge clk);
        dev_d = 1'b0;
        repeat (5) @(negedge clk);
        check_val({tag, "_frame"}, got, model_frame(b));
        check_val({tag, "_done"}, n_done, ack ? 1 : 0);
        check_val({tag, "_err"}, n_err, ack ? 0 : 1);
        check_val({tag, "_both"}, n_both, 0);
        check_val({tag, "_idle"}, tx_idle, 1);
        check_val({tag, "_lines"}, {ps2c, ps2d}, 2'b11);
    endtask

    initial begin
        int          len;
        int          t;
        logic        smp;
        logic [7:0]  rb;
        logic        rack;
        reset  = 1'b0;
        wr_ps2 = 1'b0;
        din    = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_idle", tx_idle, 1);
        check_val("rst_ticks", {tx_done_tick, tx_err}, 2'b00);
        check_val("rst_lines", {ps2c, ps2d}, 2'b11);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        do_xfer("set_led", 8'hED, 1'b1, 1'b0, 1'b0);
        do_xfer("b01", 8'h01, 1'b1, 1'b0, 1'b0);
        do_xfer("bff", 8'hFF, 1'b1, 1'b0, 1'b0);
        do_xfer("b00", 8'h00, 1'b1, 1'b0, 1'b0);
        do_xfer("nack", 8'h3C, 1'b0, 1'b0, 1'b0);
        do_xfer("wr_ignored", 8'hED, 1'b1, 1'b0, 1'b1);
        do_xfer("glitch", 8'h96, 1'b1, 1'b1, 1'b0);

        // Device never clocks: watchdog fires TIMEOUT cycles into START
        n_done = 0;
        n_err  = 0;
        start_req(8'hF4);
        measure_rts(len);
        check_val("to_rts_len", len, INHIBIT);
        t = 0;
        while (tx_err !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("to_latency", t, TIMEOUT);
        @(negedge clk);
        check_val("to_lines", {ps2c, ps2d}, 2'b11);
        check_val("to_idle", tx_idle, 1);
        check_val("to_counts", {n_done[7:0], n_err[7:0]}, {8'd0, 8'd1});

        // Reset in the middle of DATA
        start_req(8'h5A);
        measure_rts(len);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 4; i++) dev_pulse(smp, 1'b0, 1'b0);
        n_done = 0;
        n_err  = 0;
        reset  = 1'b0;
        @(negedge clk);
        check_val("mid_rst_lines", {ps2c, ps2d}, 2'b11);
        check_val("mid_rst_idle", tx_idle, 1);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_val("mid_rst_ticks", {n_done[7:0], n_err[7:0]}, 16'd0);
        do_xfer("echo", 8'hEE, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            do_xfer($sformatf("rnd%0d", k), rb, rack, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run can never hang
    initial begin
        #5ms;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1);
    end

endmodule
